// File: rtl/aes_sbox_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_sched_pkg
// Brief    : Shared types and constants for the masked S-box scheduler.
// Revision : 1.0
// ============================================================================
package aes_sbox_sched_pkg;

    typedef struct packed {
        logic valid;
        logic key;
    } tag_t;

    localparam logic SRC_KEY = 1'b1;
    localparam logic SRC_ST  = 1'b0;

    localparam int            ISSUED_W   = 5;
    localparam logic [ISSUED_W-1:0] ISSUED_MAX = 5'd31;

endpackage
`default_nettype wire

// File: rtl/sbox_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sbox_tag_pipe
// Brief    : Owner-tag delay line matching the S-box latency, plus in-flight OR.
// Revision : 1.0
// ============================================================================
module sbox_tag_pipe
    import aes_sbox_sched_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t r_stage [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | r_stage[i].valid;
        end
    end

    assign tag_out = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/aes_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_sched
// Brief    : Round-robin issue of key/state masked bytes into one shared S-box.
// Revision : 1.0
// ============================================================================
module aes_sbox_sched
    import aes_sbox_sched_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int LATENCY = 5
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  KeyReqxSI,
    input  logic [8*SHARES-1:0]   KeyXxDI,
    output logic                  KeyAckxSO,
    input  logic                  StReqxSI,
    input  logic [8*SHARES-1:0]   StXxDI,
    output logic                  StAckxSO,
    input  logic                  RndValidxSI,
    output logic                  RndTakexSO,
    output logic [8*SHARES-1:0]   SboxXxDO,
    output logic                  SboxInValidxSO,
    input  logic [8*SHARES-1:0]   SboxQxDI,
    output logic [8*SHARES-1:0]   QxDO,
    output logic                  KeyQValidxSO,
    output logic                  StQValidxSO,
    output logic                  BusyxSO,
    output logic [ISSUED_W-1:0]   IssuedxDO
);

    logic                r_last_key;
    logic [8*SHARES-1:0] r_sbox_x;
    logic                r_in_valid;
    logic                r_in_key;
    logic [ISSUED_W-1:0] r_issued;

    logic w_key_grant;
    logic w_st_grant;
    logic w_accept;
    logic w_pipe_busy;
    tag_t w_tag_in;
    tag_t w_tag_out;

    // Reset gating keeps the acks low while the block is held in reset.
    assign w_key_grant = RstxBI & RndValidxSI & KeyReqxSI & (~StReqxSI | ~r_last_key);
    assign w_st_grant  = RstxBI & RndValidxSI & StReqxSI  & (~KeyReqxSI | r_last_key);
    assign w_accept    = w_key_grant | w_st_grant;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_last_key <= SRC_ST;
            r_sbox_x   <= '0;
            r_in_valid <= 1'b0;
            r_in_key   <= SRC_ST;
            r_issued   <= '0;
        end else begin
            r_in_valid <= w_accept;
            if (w_accept) begin
                // Data only moves on accept so fresh randomness never meets stale shares.
                r_sbox_x   <= w_key_grant ? KeyXxDI : StXxDI;
                r_last_key <= w_key_grant;
                r_in_key   <= w_key_grant;
                if (r_issued != ISSUED_MAX) begin
                    r_issued <= r_issued + 1'b1;
                end
            end else begin
                r_in_key <= SRC_ST;
                if (!BusyxSO) begin
                    r_issued <= '0;
                end
            end
        end
    end

    // The tag follows the S-box input register, so it enters the delay line one cycle after accept.
    assign w_tag_in = '{valid: r_in_valid, key: r_in_key};

    sbox_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk       (ClkxCI),
        .rst_n     (RstxBI),
        .tag_in    (w_tag_in),
        .tag_out   (w_tag_out),
        .any_valid (w_pipe_busy)
    );

    assign KeyAckxSO      = w_key_grant;
    assign StAckxSO       = w_st_grant;
    assign RndTakexSO     = w_accept;
    assign SboxXxDO       = r_sbox_x;
    assign SboxInValidxSO = r_in_valid;
    assign QxDO           = SboxQxDI;
    assign KeyQValidxSO   = w_tag_out.valid & w_tag_out.key;
    assign StQValidxSO    = w_tag_out.valid & ~w_tag_out.key;
    assign BusyxSO        = r_in_valid | w_pipe_busy;
    assign IssuedxDO      = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sbox_sched
// Brief    : Randomized and directed self-checking bench for aes_sbox_sched.
// Revision : 1.0
// ============================================================================
module tb_aes_sbox_sched;

    localparam int SHARES  = 2;
    localparam int LATENCY = 5;
    localparam int W       = 8 * SHARES;
    localparam int MAXC    = 8192;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         kreq, sreq, rnd;
    logic [W-1:0] kx, sx, sq;
    logic         kack, sack, rtake, inval, kqv, sqv, busy;
    logic [W-1:0] sbox_x, q;
    logic [4:0]   issued;

    always #5 clk = ~clk;

    aes_sbox_sched #(.SHARES(SHARES), .LATENCY(LATENCY)) dut (
        .ClkxCI         (clk),
        .RstxBI         (rst_n),
        .KeyReqxSI      (kreq),
        .KeyXxDI        (kx),
        .KeyAckxSO      (kack),
        .StReqxSI       (sreq),
        .StXxDI         (sx),
        .StAckxSO       (sack),
        .RndValidxSI    (rnd),
        .RndTakexSO     (rtake),
        .SboxXxDO       (sbox_x),
        .SboxInValidxSO (inval),
        .SboxQxDI       (sq),
        .QxDO           (q),
        .KeyQValidxSO   (kqv),
        .StQValidxSO    (sqv),
        .BusyxSO        (busy),
        .IssuedxDO      (issued)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: arbitration pointer, input register, and a per-cycle result calendar.
    bit           m_last_key;
    logic [W-1:0] m_sbox;
    bit           m_inval;
    int           m_issued;
    int           last_acc;
    bit           res_key [MAXC];
    bit           res_st  [MAXC];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit k, input bit s, input bit rv,
                        input logic [W-1:0] kd, input logic [W-1:0] sd);
        bit ek, es, eb;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = r; kreq = k; sreq = s; rnd = rv; kx = kd; sx = sd;
        sq = W'($urandom);
        if (!r) begin
            m_last_key = 1'b0; m_sbox = '0; m_inval = 1'b0; m_issued = 0; last_acc = -100;
            for (int i = 0; i <= LATENCY + 2; i++) begin
                res_key[cyc+i] = 1'b0;
                res_st[cyc+i]  = 1'b0;
            end
        end
        #3;
        ek = r && rv && k && (!s || !m_last_key);
        es = r && rv && s && (!k || m_last_key);
        eb = (cyc - last_acc >= 1) && (cyc - last_acc <= LATENCY + 1);
        chk("key_ack",   W'(kack),   W'(ek));
        chk("st_ack",    W'(sack),   W'(es));
        chk("rnd_take",  W'(rtake),  W'(ek | es));
        chk("sbox_x",    sbox_x,     m_sbox);
        chk("sbox_inv",  W'(inval),  W'(m_inval));
        chk("key_qv",    W'(kqv),    W'(res_key[cyc]));
        chk("st_qv",     W'(sqv),    W'(res_st[cyc]));
        chk("q_pass",    q,          sq);
        chk("busy",      W'(busy),   W'(eb));
        chk("issued",    W'(issued), W'(m_issued));
        if (r) begin
            if (ek || es) begin
                m_sbox     = ek ? kd : sd;
                m_inval    = 1'b1;
                m_last_key = ek;
                res_key[cyc+LATENCY+1] = ek;
                res_st[cyc+LATENCY+1]  = es;
                last_acc   = cyc;
                m_issued   = (m_issued < 31) ? m_issued + 1 : 31;
            end else begin
                m_inval = 1'b0;
                if (!eb) m_issued = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1, W'($urandom), W'($urandom));
    endtask

    initial begin
        bit [5:0] pat;
        rst_n = 1'b0; kreq = 1'b0; sreq = 1'b0; rnd = 1'b0; kx = '0; sx = '0; sq = '0;
        m_last_key = 1'b0; m_sbox = '0; m_inval = 1'b0; m_issued = 0; last_acc = -100;
        for (int i = 0; i < MAXC; i++) begin res_key[i] = 1'b0; res_st[i] = 1'b0; end

        // Reset with both requests high: everything reads zero.
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);
        chk("rst_ack",    W'(kack | sack | rtake), '0);
        chk("rst_issued", W'(issued), '0);
        idle(2);

        // Single key request.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0053, 16'hAAAA);
        chk("single_ack", W'(kack), W'(1));
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (i == 1) begin
                chk("single_sbox", sbox_x, 16'h0053);
                chk("single_inv",  W'(inval), W'(1));
            end
            if (i == 6) begin
                chk("single_kqv", W'(kqv), W'(1));
                chk("single_sqv", W'(sqv), W'(0));
            end
        end
        idle(3);

        // Tie alternation from reset.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
            pat[5-i] = kack;
        end
        chk("tie_pattern", W'(pat), W'(6'b101010));
        idle(8);

        // Randomness stall.
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
        repeat (3) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom));
            chk("stall_take", W'(rtake), W'(0));
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
        chk("stall_resume", W'(rtake), W'(1));
        idle(10);

        // Full round: 4 key bytes then 16 state bytes back to back.
        repeat (4)  step(1'b1, 1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom));
        repeat (16) step(1'b1, 1'b0, 1'b1, 1'b1, W'($urandom), W'($urandom));
        idle(1);
        chk("round_issued", W'(issued), W'(20));
        idle(5);
        chk("round_busy_hi", W'(busy), W'(1));
        idle(1);
        chk("round_busy_lo", W'(busy), W'(0));
        chk("round_hold",    W'(issued), W'(20));
        idle(1);
        chk("round_clear",   W'(issued), W'(0));

        // Saturation.
        repeat (40) step(1'b1, 1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom));
        idle(1);
        chk("sat_issued", W'(issued), W'(31));
        idle(10);

        // Reset mid-flight after three key accepts.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom));
        idle(2);
        step(1'b0, 1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
        chk("mid_rst_out", W'({kack, sack, rtake, inval, kqv, sqv, busy}), '0);
        chk("mid_rst_x",   sbox_x, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        idle(8);
        step(1'b1, 1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
        chk("mid_rst_tie", W'(kack), W'(1));
        idle(8);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 W'($urandom), W'($urandom));
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
